// File: rtl/reg_file_mp.sv
// Multi-port register file with prioritised writes, optional write-to-read
// bypass and a busy-bit scoreboard for destination-register reservations.

module reg_file_mp_rd_lane #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        reg_val,
  input  logic                     busy_bit,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_busy
);
  logic              zero;
  logic              hit;
  logic [DATA_W-1:0] byp;

  always_comb begin
    zero = (ZERO_REG != 0) && (rd_addr == '0);
    hit  = 1'b0;
    byp  = '0;
    // later ports overwrite earlier matches: highest index wins
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
        hit = 1'b1;
        byp = wr_data[j*DATA_W +: DATA_W];
      end
    end
    rd_data = reg_val;
    rd_busy = busy_bit;
    if (zero) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end else if ((BYPASS != 0) && hit) begin
      rd_data = byp;
      // a retiring write looks free unless a new producer claims it now
      if (!(rsv_en && (rsv_addr == rd_addr))) rd_busy = 1'b0;
    end
  end
endmodule

module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  input  logic                     flush_i,
  output logic [ADDR_W:0]          busy_cnt_o
);
  localparam int NREGS = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [DATA_W-1:0]              regs [NREGS];
  logic [NREGS-1:0]               busy, busy_nxt;
  logic [ADDR_W:0]                busy_cnt, busy_cnt_nxt;
  logic [NUM_RD-1:0][DATA_W-1:0]  lane_val;
  logic                           rsv_ok;

  assign rsv_ok = rsv_en_i && !((ZERO_REG != 0) && (rsv_addr_i == '0));

  // Release first, then reserve, so a same-cycle reserve wins; flush beats both.
  always_comb begin
    busy_nxt = busy;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en_i[j]) busy_nxt[wr_addr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr_i] = 1'b1;
    if (flush_i) busy_nxt = '0;

    busy_cnt_nxt = busy_cnt;
    for (int i = 0; i < NREGS; i++) begin
      if (busy_nxt[i] && !busy[i])      busy_cnt_nxt = busy_cnt_nxt + CNT_ONE;
      else if (!busy_nxt[i] && busy[i]) busy_cnt_nxt = busy_cnt_nxt - CNT_ONE;
    end
    if (flush_i) busy_cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en_i[j] && !((ZERO_REG != 0) && (wr_addr_i[j*ADDR_W +: ADDR_W] == '0)))
          regs[wr_addr_i[j*ADDR_W +: ADDR_W]] <= wr_data_i[j*DATA_W +: DATA_W];
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt_nxt;
    end
  end

  assign busy_cnt_o = busy_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign lane_val[k] = regs[rd_addr_i[k*ADDR_W +: ADDR_W]];

    reg_file_mp_rd_lane #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_lane (
      .rd_addr  (rd_addr_i[k*ADDR_W +: ADDR_W]),
      .reg_val  (lane_val[k]),
      .busy_bit (busy[rd_addr_i[k*ADDR_W +: ADDR_W]]),
      .wr_en    (wr_en_i),
      .wr_addr  (wr_addr_i),
      .wr_data  (wr_data_i),
      .rsv_en   (rsv_en_i),
      .rsv_addr (rsv_addr_i),
      .rd_data  (rd_data_o[k*DATA_W +: DATA_W]),
      .rd_busy  (rd_busy_o[k])
    );
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (2 read, 2 write ports, bypass on): directed scenarios
// plus random traffic against an array-based reference model.

module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;
  logic [5:0]  busy_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rsv_en_i(rsv_en),
    .rsv_addr_i(rsv_addr), .flush_i(flush), .busy_cnt_o(busy_cnt)
  );

  // ---- reference model ----
  function automatic logic [4:0] ra(int k);
    return rd_addr[k*5 +: 5];
  endfunction

  function automatic logic [31:0] exp_data(int k);
    logic [4:0]  a = ra(k);
    logic [31:0] d = m_regs[a];
    if (a == 0) return 32'h0;
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*5 +: 5] == a) d = wr_data[j*32 +: 32];
    return d;
  endfunction

  function automatic logic exp_busy(int k);
    logic [4:0] a = ra(k);
    bit written = 0;
    if (a == 0) return 1'b0;
    for (int j = 0; j < 2; j++) if (wr_en[j] && wr_addr[j*5 +: 5] == a) written = 1;
    if (written && !(rsv_en && rsv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [5:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return 6'(n);
  endfunction

  // advance one edge and apply the same edge to the model, then release inputs
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
    end else begin
      for (int j = 0; j < 2; j++)
        if (wr_en[j] && wr_addr[j*5 +: 5] != 0) m_regs[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        for (int j = 0; j < 2; j++) if (wr_en[j]) m_busy[wr_addr[j*5 +: 5]] = 0;
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
      end
    end
    #1;
    rst_n = 1; wr_en = 0; rsv_en = 0; flush = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
    wr_en[j] = 1'b1; wr_addr[j*5 +: 5] = a; wr_data[j*32 +: 32] = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 0; tick();
    rd(5'd5, 5'd7);
    @(negedge clk);
    total += 3;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data); end
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", rd_busy); end
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
    tick();
  endtask

  task automatic test_write_bypass();
    wr(0, 5'd5, 32'hDEADBEEF); rd(5'd5, 5'd5);
    @(negedge clk);
    total += 2;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL byp_p0 got=%h exp=deadbeef", rd_data[31:0]); end
    if (rd_data[63:32] !== 32'hDEADBEEF) begin bad++; $display("FAIL byp_p1 got=%h exp=deadbeef", rd_data[63:32]); end
    tick();
    @(negedge clk);
    total++;
    if (rd_data !== {2{32'hDEADBEEF}}) begin bad++; $display("FAIL stored_r5 got=%h exp=deadbeef x2", rd_data); end
    tick();
  endtask

  task automatic test_write_priority();
    wr(0, 5'd7, 32'h11111111); wr(1, 5'd7, 32'h22222222); rd(5'd7, 5'd0);
    @(negedge clk);
    total++;
    if (rd_data[31:0] !== 32'h22222222) begin bad++; $display("FAIL prio_byp got=%h exp=22222222", rd_data[31:0]); end
    tick();
    wr(0, 5'd0, 32'hFFFFFFFF); rd(5'd7, 5'd0);
    @(negedge clk);
    total += 2;
    if (rd_data[31:0] !== 32'h22222222) begin bad++; $display("FAIL prio_r7 got=%h exp=22222222", rd_data[31:0]); end
    if (rd_data[63:32] !== 32'h0) begin bad++; $display("FAIL r0_byp got=%h exp=0", rd_data[63:32]); end
    tick();
    @(negedge clk);
    total++;
    if (rd_data[63:32] !== 32'h0) begin bad++; $display("FAIL r0_stored got=%h exp=0", rd_data[63:32]); end
    tick();
  endtask

  task automatic test_reserve_release();
    rsv(5'd3); rd(5'd3, 5'd3);
    tick();
    @(negedge clk);
    total += 2;
    if (rd_busy !== 2'b11) begin bad++; $display("FAIL rsv_busy got=%b exp=11", rd_busy); end
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL rsv_cnt got=%0d exp=1", busy_cnt); end
    tick();
    wr(1, 5'd3, 32'h5A);
    @(negedge clk);
    total += 2;
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL rel_busy_byp got=%b exp=00", rd_busy); end
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL rel_cnt_same got=%0d exp=1", busy_cnt); end
    tick();
    @(negedge clk);
    total += 3;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rel_cnt got=%0d exp=0", busy_cnt); end
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL rel_busy got=%b exp=00", rd_busy); end
    if (rd_data[31:0] !== 32'h5A) begin bad++; $display("FAIL rel_data got=%h exp=5a", rd_data[31:0]); end
    tick();
  endtask

  task automatic test_rsv_write_same();
    rsv(5'd9); wr(0, 5'd9, 32'h99); rd(5'd9, 5'd9);
    tick();
    @(negedge clk);
    total += 3;
    if (rd_busy !== 2'b11) begin bad++; $display("FAIL same_busy got=%b exp=11", rd_busy); end
    if (busy_cnt !== 6'd1) begin bad++; $display("FAIL same_cnt got=%0d exp=1", busy_cnt); end
    if (rd_data[31:0] !== 32'h99) begin bad++; $display("FAIL same_data got=%h exp=99", rd_data[31:0]); end
    wr(0, 5'd9, 32'h98);
    tick();
  endtask

  task automatic test_flush();
    rsv(5'd1); tick();
    rsv(5'd2); tick();
    rsv(5'd4); tick();
    @(negedge clk);
    total++;
    if (busy_cnt !== 6'd3) begin bad++; $display("FAIL three_cnt got=%0d exp=3", busy_cnt); end
    flush = 1; rsv(5'd6); wr(0, 5'd10, 32'h1234);
    tick();
    rd(5'd6, 5'd10);
    @(negedge clk);
    total += 3;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", busy_cnt); end
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL flush_busy got=%b exp=00", rd_busy); end
    if (rd_data[63:32] !== 32'h1234) begin bad++; $display("FAIL flush_wr got=%h exp=1234", rd_data[63:32]); end
    rsv(5'd0);
    tick();
    @(negedge clk);
    total++;
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rsv_r0_cnt got=%0d exp=0", busy_cnt); end
  endtask

  task automatic test_reset_mid();
    wr(0, 5'd8, 32'hAA); rsv(5'd11); tick();
    rsv(5'd12); tick();
    rst_n = 0; wr(1, 5'd8, 32'hBB); rsv(5'd13);
    tick();
    rd(5'd8, 5'd11);
    @(negedge clk);
    total += 3;
    if (rd_data !== 64'h0) begin bad++; $display("FAIL rstmid_data got=%h exp=0", rd_data); end
    if (rd_busy !== 2'b00) begin bad++; $display("FAIL rstmid_busy got=%b exp=00", rd_busy); end
    if (busy_cnt !== 6'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", busy_cnt); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n    = ($urandom_range(0, 59) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      wr_en    = 2'($urandom);
      wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 2) != 0);
      rsv_addr = 5'($urandom_range(0, 7));
      rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      total += 5;
      for (int k = 0; k < 2; k++) begin
        if (rd_data[k*32 +: 32] !== exp_data(k)) begin
          bad++; $display("FAIL rand_data%0d cyc=%0d got=%h exp=%h", k, c, rd_data[k*32 +: 32], exp_data(k));
        end
        if (rd_busy[k] !== exp_busy(k)) begin
          bad++; $display("FAIL rand_busy%0d cyc=%0d got=%b exp=%b", k, c, rd_busy[k], exp_busy(k));
        end
      end
      if (busy_cnt !== exp_cnt()) begin
        bad++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", c, busy_cnt, exp_cnt());
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 0; rsv_addr = '0; flush = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_busy[i] = 0; end
    test_reset();
    test_write_bypass();
    test_write_priority();
    test_reserve_release();
    test_rsv_write_same();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the ID stage, successor to the original 2-read/1-write 32×32 file. It provides NUM_RD combinational read ports and NUM_WR write ports with deterministic write priority and optional same-cycle write-to-read bypass. An integrated busy-bit scoreboard lets ID reserve destination registers at issue and release them at write-back, so the hazard unit can stall on pending results.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; NREGS = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (≥1)
- NUM_WR, 1, number of write ports (≥1)
- ZERO_REG, 1, 1 = register 0 is hard-wired to zero and never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data_o  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy_o  out  NUM_RD  port k's register has an outstanding reservation
- wr_en_i  in  NUM_WR  write enable per write port
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses
- wr_data_i  in  NUM_WR*DATA_W  write data
- rsv_en_i  in  1  reserve (mark busy) rsv_addr_i at next edge
- rsv_addr_i  in  ADDR_W  register to reserve
- flush_i  in  1  clear all busy bits at next edge (pipeline flush)
- busy_cnt_o  out  ADDR_W+1  number of registers currently busy

## Operation
- State: regs[NREGS] of DATA_W, busy[NREGS] bits, busy counter.
- Write: at edge, for each port j with wr_en_i[j], regs[wr_addr[j]] <= wr_data[j]. Writes to addr 0 are dropped when ZERO_REG=1.
- Multiple ports writing the same address in one cycle: highest-index port wins.
- Read (combinational): if BYPASS=1 and any enabled write port matches rd_addr (and the address is not zero-suppressed), output the data of the highest-index matching port. Otherwise output regs[rd_addr]. Addr 0 reads 0 when ZERO_REG=1.
- Scoreboard, per register at the edge:
  - Any enabled write port to the address clears busy.
  - rsv_en_i to the address sets busy.
  - Reserve and write to the same address in one cycle: set wins (the new producer supersedes the retiring one).
  - flush_i clears every busy bit and overrides reserve and release in that cycle. Register writes still occur.
  - Reserving address 0 is ignored when ZERO_REG=1.
- rd_busy_o[k] = busy[rd_addr_k]. When BYPASS=1 it is forced to 0 if a same-cycle enabled write matches, unless rsv_en_i also targets that address in the same cycle.
- busy_cnt_o equals popcount(busy) at all times. It is maintained incrementally: +1 on a set of a clear bit, −1 per distinct busy bit cleared, 0 on flush. It never exceeds NREGS − ZERO_REG.

## Timing
- Reset (rst_n=0 at edge): all regs = 0, all busy = 0, busy_cnt_o = 0. rd_data_o reads 0 and rd_busy_o = 0 on the following cycle, except for bypassed write data.
- Reset dominates write, reserve and flush in the same cycle. Reset asserted mid-operation discards all pending reservations.
- Write-to-read latency: 0 cycles with BYPASS=1 (combinational path), 1 cycle with BYPASS=0.
- Reserve-to-busy latency: 1 cycle. A reservation made in cycle N is visible on rd_busy_o in cycle N+1.
- busy_cnt_o is registered and updates 1 cycle after the causing event.
- No handshake. All inputs are sampled every cycle. There is no back-pressure.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via port 0. Read r5 on both read ports in the same cycle → 0xDEADBEEF with BYPASS=1. With BYPASS=0 → 0 in that cycle, 0xDEADBEEF in the next.
- NUM_WR=2: ports 0 and 1 both write r7 (0x11111111 and 0x22222222) → r7 = 0x22222222 and the bypass shows 0x22222222. Write r0 = 0xFFFFFFFF → r0 reads 0.
- Reserve r3 → next cycle rd_busy=1 and busy_cnt_o=1. Write r3 = 0x5A → rd_busy=0 in the same cycle (bypass), the busy bit clears at the edge, and busy_cnt_o=0 next cycle.
- Reserve r9 and write r9 in the same cycle → r9 remains busy, regs[r9] updated, busy_cnt_o=1.
- Reserve r1, r2, r4 → busy_cnt_o=3. Assert flush_i together with a reserve of r6 → all busy=0 and busy_cnt_o=0. Reserving r0 leaves the count unchanged.
- With regs and busy bits populated, drive rst_n=0 for one cycle along with a write to r8 → all reads 0, rd_busy_o=0, busy_cnt_o=0, and r8 not written.
